branch_resolve_ctrl: RTL
========================

// Module: branch_resolve_ctrl
// PURPOSE
//  Sequences the branch comparator in the EX stage.
//  - Decodes the branch funct3 and drives br_un to the comparator.
//  - Combines the comparator's br_eq/br_lt into a taken decision and checks it against the fetch-stage prediction.
//  - On a mispredict, issues a one-cycle redirect and flushes for a fixed number of cycles.
//  - Owns the 2-bit saturating branch history table (BHT) that fetch reads for predictions.
// PARAMETERS
//  REG_WIDTH     `REG_WIDTH  data and PC width
//  BHT_IDX_BITS  6           BHT has 2**BHT_IDX_BITS entries, indexed by pc[BHT_IDX_BITS+1:2]
//  FLUSH_CYCLES  2           cycles flush is held after a mispredict (legal range 1..15)
// PORTS
//  clk            in   1          single clock; all state updates on rising edge
//  rst            in   1          synchronous, active-high reset
//  br_valid       in   1          EX holds a branch
//  br_ready       out  1          controller can accept a branch
//  br_funct3      in   3          branch funct3
//  br_pc          in   REG_WIDTH  PC of the branch
//  br_imm         in   REG_WIDTH  sign-extended B-immediate
//  br_pred_taken  in   1          prediction made at fetch for this branch
//  br_un          out  1          to comparator: 1 = unsigned compare
//  br_eq          in   1          from comparator
//  br_lt          in   1          from comparator
//  lookup_pc      in   REG_WIDTH  fetch PC for prediction
//  pred_taken     out  1          combinational BHT read: MSB of entry[lookup_pc idx]
//  redirect       out  1          one-cycle pulse: fetch must load redirect_pc
//  redirect_pc    out  REG_WIDTH  corrected fetch PC
//  flush          out  1          kill IF/ID contents
//  illegal_br     out  1          one-cycle pulse on accepted funct3 010/011
// BEHAVIOUR
//  Reset (rst=1 at edge):
//   - state <= IDLE.
//   - redirect, flush, illegal_br <= 0; redirect_pc <= 0.
//   - Every BHT entry <= 2'b01 (weakly not-taken).
//   - Reset overrides any in-flight redirect/flush.
//  br_un = br_funct3[1] (combinational); comparator inputs come straight from EX.
//  Taken decode:
//   - 000 BEQ: br_eq
//   - 001 BNE: !br_eq
//   - 100/110 BLT/BLTU: br_lt
//   - 101/111 BGE/BGEU: !br_lt
//   - 010/011: illegal, treated as not-taken
//  Accept = br_valid & br_ready (edge N). br_ready = (state==IDLE).
//  Target: taken ? br_pc+br_imm : br_pc+4, computed modulo 2**REG_WIDTH (wrap ignored).
//  mispredict = (taken != br_pred_taken).
//  FSM states IDLE, REDIRECT, FLUSH:
//   - IDLE: on accept with mispredict, go to REDIRECT at N+1; otherwise stay in IDLE (back-to-back accepts allowed).
//   - REDIRECT (cycle N+1): redirect=1, flush=1, redirect_pc=target registered at N. Then:
//     - FLUSH_CYCLES==1: go to IDLE.
//     - otherwise: go to FLUSH with cnt=FLUSH_CYCLES-2.
//   - FLUSH: flush=1, redirect=0; decrement cnt; go to IDLE when cnt==0.
//  Timing: flush is high for exactly FLUSH_CYCLES cycles (N+1..N+FLUSH_CYCLES); br_ready is next 1 at N+FLUSH_CYCLES+1.
//  br_valid is ignored while br_ready=0; the upstream stage must hold the branch.
//  illegal_br: pulse at N+1.
//   - BHT is not updated.
//   - Mispredict is still checked, so pred_taken=1 redirects to pc+4.
//  BHT update at accept edge (legal funct3 only): taken -> increment, else decrement; saturate at 2'b11 / 2'b00.
//  BHT read/write to the same index in the same cycle: pred_taken returns the old value; the new value is visible next cycle.
//  redirect_pc holds its last value outside REDIRECT.
// TESTING
//  1. rst 1 cycle, then lookup any pc -> pred_taken=0; br_ready=1; all outputs 0.
//  2. BEQ pc=0x100 imm=0x40 eq=1 pred=0:
//     - redirect=1, redirect_pc=0x140 at N+1;
//     - flush high N+1..N+2, br_ready=0 N+1..N+2, 1 at N+3.
//  3. BLTU rs1=0xFFFFFFFF rs2=1 -> br_un=1, lt=0, not-taken, pred=0:
//     - no redirect; next branch accepted at N+1 (back-to-back);
//     - BHT[idx(pc)] goes 01->00.
//  4. Four taken BNE at pc=0x200:
//     - pred_taken(0x200) steps 0,1,1,1 (entry 01->10->11->11, saturates);
//     - a same-cycle lookup returns the pre-update value.
//  5. funct3=010, pred=1, pc=0x300 -> illegal_br pulse; redirect_pc=0x304; BHT entry unchanged.
//  6. rst asserted at N+1 of a mispredict -> redirect/flush 0 and br_ready 1 at N+2; BHT back to 01.

Source files
------------

// File: rtl/branch_resolve_ctrl_if.sv
// ---------------------------------------------------------------------------
// branch_resolve_ctrl_if
// Groups the EX-stage branch handshake, the comparator hookup and the
// fetch-side prediction/redirect signals of the branch resolve controller.
//
//   br_valid      EX holds a branch                     (master -> slave)
//   br_ready      controller can accept a branch        (slave  -> master)
//   br_funct3     branch funct3                         (master -> slave)
//   br_pc         PC of the branch                      (master -> slave)
//   br_imm        sign-extended B-immediate             (master -> slave)
//   br_pred_taken fetch-time prediction for the branch  (master -> slave)
//   br_un         comparator mode, 1 = unsigned         (slave  -> master)
//   br_eq, br_lt  comparator results                    (master -> slave)
//   lookup_pc     fetch PC to predict                   (master -> slave)
//   pred_taken    BHT prediction for lookup_pc          (slave  -> master)
//   redirect      one-cycle fetch redirect pulse        (slave  -> master)
//   redirect_pc   corrected fetch PC                    (slave  -> master)
//   flush         kill IF/ID contents                   (slave  -> master)
//   illegal_br    one-cycle pulse on illegal funct3     (slave  -> master)
// ---------------------------------------------------------------------------
interface branch_resolve_ctrl_if #(
    parameter int REG_WIDTH = 32
);
    logic                 br_valid;
    logic                 br_ready;
    logic [2:0]           br_funct3;
    logic [REG_WIDTH-1:0] br_pc;
    logic [REG_WIDTH-1:0] br_imm;
    logic                 br_pred_taken;
    logic                 br_un;
    logic                 br_eq;
    logic                 br_lt;
    logic [REG_WIDTH-1:0] lookup_pc;
    logic                 pred_taken;
    logic                 redirect;
    logic [REG_WIDTH-1:0] redirect_pc;
    logic                 flush;
    logic                 illegal_br;

    modport master (
        output br_valid, br_funct3, br_pc, br_imm, br_pred_taken,
               br_eq, br_lt, lookup_pc,
        input  br_ready, br_un, pred_taken, redirect, redirect_pc,
               flush, illegal_br
    );

    modport slave (
        input  br_valid, br_funct3, br_pc, br_imm, br_pred_taken,
               br_eq, br_lt, lookup_pc,
        output br_ready, br_un, pred_taken, redirect, redirect_pc,
               flush, illegal_br
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// branch_resolve_ctrl
// Resolves conditional branches in EX: decodes funct3 for the comparator,
// forms the taken decision, checks it against the fetch prediction and, on
// a mispredict, issues a one-cycle redirect followed by a flush lasting
// FLUSH_CYCLES cycles. Also owns the 2-bit saturating BHT read by fetch.
//
// Ports:
//   clk   single clock, all state updates on the rising edge
//   rst   synchronous, active-high reset
//   bus   branch_resolve_ctrl_if slave modport (handshake, comparator,
//         prediction lookup, redirect/flush/illegal outputs)
// ---------------------------------------------------------------------------
module branch_resolve_ctrl #(
    parameter int REG_WIDTH    = 32,
    parameter int BHT_IDX_BITS = 6,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_resolve_ctrl_if.slave bus
);

    localparam int BHT_ENTRIES = 1 << BHT_IDX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        FLUSH
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_next;
    logic [1:0]              r_bht [BHT_ENTRIES];
    logic [REG_WIDTH-1:0]    r_redirect_pc;
    logic                    r_illegal;

    logic                    w_taken;
    logic                    w_illegal;
    logic                    w_accept;
    logic                    w_mispredict;
    logic                    w_ready;
    logic                    w_redirect;
    logic                    w_flush;
    logic [REG_WIDTH-1:0]    w_target;
    logic [BHT_IDX_BITS-1:0] w_br_idx;
    logic [BHT_IDX_BITS-1:0] w_lookup_idx;
    logic                    w_unused;

    // Word-aligned PCs: bits [1:0] never vary, so the BHT index starts at bit 2.
    assign w_br_idx     = bus.br_pc[BHT_IDX_BITS+1:2];
    assign w_lookup_idx = bus.lookup_pc[BHT_IDX_BITS+1:2];
    assign w_unused     = ^{bus.lookup_pc[REG_WIDTH-1:BHT_IDX_BITS+2],
                            bus.lookup_pc[1:0]};

    // funct3 bit 1 separates the unsigned compares (BLTU/BGEU) from the rest.
    assign bus.br_un = bus.br_funct3[1];

    // Taken decode; 010/011 are not branches and resolve as not-taken.
    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        case (bus.br_funct3)
            3'b000:         w_taken = bus.br_eq;
            3'b001:         w_taken = !bus.br_eq;
            3'b100, 3'b110: w_taken = bus.br_lt;
            3'b101, 3'b111: w_taken = !bus.br_lt;
            default:        w_illegal = 1'b1;
        endcase
    end

    assign w_accept     = bus.br_valid & w_ready;
    assign w_mispredict = (w_taken != bus.br_pred_taken);
    assign w_target     = w_taken ? (bus.br_pc + bus.br_imm)
                                  : (bus.br_pc + REG_WIDTH'(4));

    // Next-state and Moore outputs. REDIRECT always counts as the first
    // flush cycle, so FLUSH only covers the remaining FLUSH_CYCLES-1.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_ready      = 1'b0;
        w_redirect   = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (w_accept && w_mispredict) begin
                    w_state_next = REDIRECT;
                end
            end
            REDIRECT: begin
                w_redirect = 1'b1;
                w_flush    = 1'b1;
                if (FLUSH_CYCLES == 1) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = FLUSH;
                    w_cnt_next   = 4'(FLUSH_CYCLES - 2);
                end
            end
            FLUSH: begin
                w_flush = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register; reset wins over any redirect/flush in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Redirect target is captured at the accept edge and then held, so the
    // value seen during REDIRECT is the one for the mispredicted branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_pc <= '0;
            r_illegal     <= 1'b0;
        end else begin
            r_illegal <= w_accept & w_illegal;
            if (w_accept && w_mispredict) begin
                r_redirect_pc <= w_target;
            end
        end
    end

    // 2-bit saturating counters; illegal encodings leave the table alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_accept && !w_illegal) begin
            if (w_taken && (r_bht[w_br_idx] != 2'b11)) begin
                r_bht[w_br_idx] <= r_bht[w_br_idx] + 2'b01;
            end else if (!w_taken && (r_bht[w_br_idx] != 2'b00)) begin
                r_bht[w_br_idx] <= r_bht[w_br_idx] - 2'b01;
            end
        end
    end

    // Read uses the registered table, so a same-cycle update is not yet seen.
    assign bus.pred_taken  = r_bht[w_lookup_idx][1];
    assign bus.br_ready    = w_ready;
    assign bus.redirect    = w_redirect;
    assign bus.flush       = w_flush;
    assign bus.redirect_pc = r_redirect_pc;
    assign bus.illegal_br  = r_illegal;

endmodule
